// File: rtl/header_insert_if.sv
// Byte-wide AXI-Stream bundle used on both sides of header_insert.
// master drives data/valid/last and samples ready; slave is the mirror image.
interface header_insert_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/header_insert.sv
// header_insert: prepends a HEADER_LEN-byte header, taken from hdr_template
// and sampled once per packet, to each payload packet on a byte-wide AXIS
// stream. The output is one fully registered stage with no bubbles between
// header and payload or between packets.
//
// Optional feature: define HEADER_INSERT_LEN_PATCH_EN to overwrite the IPv4
// total-length and UDP length fields with payload_len+28 / payload_len+8 when
// the template is latched. Without it the template passes through verbatim.
module header_insert #(
    parameter int HEADER_LEN  = 42,
    parameter int IP_LEN_OFS  = 16,
    parameter int UDP_LEN_OFS = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*HEADER_LEN-1:0] hdr_template,
    input  logic [15:0]             payload_len,
    header_insert_if.slave          s_axis,
    header_insert_if.master         m_axis,
    output logic [15:0]             pkt_count
);

    localparam int HDR_W = 8 * HEADER_LEN;
    localparam int IDX_W = $clog2(HEADER_LEN) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HEADER_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic [7:0]         tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [15:0]        pkt_count_q, pkt_count_d;

    logic               load_en;
    logic               s_ready;
    logic [HDR_W-1:0]   hdr_latch;

    // ------------------------------------------------------------------
    // Header image captured at packet start (optionally length-patched)
    // ------------------------------------------------------------------
`ifdef HEADER_INSERT_LEN_PATCH_EN
    logic [15:0] ip_len;
    logic [15:0] udp_len;

    assign ip_len  = payload_len + 16'd28;
    assign udp_len = payload_len + 16'd8;

    // The template bytes that get overwritten are deliberately dropped.
    logic unused_tmpl_len_bytes;
    assign unused_tmpl_len_bytes = ^{hdr_template[HDR_W-1-8*IP_LEN_OFS  -: 16],
                                     hdr_template[HDR_W-1-8*UDP_LEN_OFS -: 16]};

    genvar gi;
    generate
        for (gi = 0; gi < HEADER_LEN; gi++) begin : g_patch
            if (gi == IP_LEN_OFS) begin : g_ip_hi
                assign hdr_latch[HDR_W-1-8*gi -: 8] = ip_len[15:8];
            end else if (gi == IP_LEN_OFS + 1) begin : g_ip_lo
                assign hdr_latch[HDR_W-1-8*gi -: 8] = ip_len[7:0];
            end else if (gi == UDP_LEN_OFS) begin : g_udp_hi
                assign hdr_latch[HDR_W-1-8*gi -: 8] = udp_len[15:8];
            end else if (gi == UDP_LEN_OFS + 1) begin : g_udp_lo
                assign hdr_latch[HDR_W-1-8*gi -: 8] = udp_len[7:0];
            end else begin : g_pass
                assign hdr_latch[HDR_W-1-8*gi -: 8] = hdr_template[HDR_W-1-8*gi -: 8];
            end
        end
    endgenerate
`else
    // payload_len is informational only in this build.
    logic unused_payload_len;
    assign unused_payload_len = ^payload_len;
    assign hdr_latch          = hdr_template;
`endif

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    // The output register may take a new byte when it is empty or draining.
    assign load_en = !tvalid_q || m_axis.tready;
    // Payload is only pulled while in PAYLOAD, so header bytes never race it.
    assign s_ready = (state_q == PAYLOAD) && load_en;

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign pkt_count     = pkt_count_q;

    // Next-state and output-register load decisions for the framing FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hdr_d       = hdr_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        pkt_count_d = pkt_count_q;

        // A drained register with nothing new to load goes empty.
        if (load_en) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Byte 0 goes straight out; the rest are kept pre-shifted so
                // the next header byte is always the top byte of hdr_q.
                if (s_axis.tvalid && load_en) begin
                    hdr_d    = hdr_latch << 8;
                    tdata_d  = hdr_latch[HDR_W-1 -: 8];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    idx_d    = IDX_W'(1);
                    state_d  = HEADER;
                end
            end

            HEADER: begin
                if (load_en) begin
                    tdata_d  = hdr_q[HDR_W-1 -: 8];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    hdr_d    = hdr_q << 8;
                    idx_d    = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                if (s_axis.tvalid && s_ready) begin
                    tdata_d  = s_axis.tdata;
                    tvalid_d = 1'b1;
                    tlast_d  = s_axis.tlast;
                    if (s_axis.tlast) begin
                        state_d     = IDLE;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and output register, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tdata_q     <= 8'd0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Latched header image; only meaningful while a header is in flight.
    always_ff @(posedge clk) begin
        hdr_q <= hdr_d;
    end

endmodule

// File: tb/tb_header_insert.sv
// Self-checking bench for header_insert: expected framed bytes are queued when
// a packet is offered and compared as they leave m_axis.
module tb_header_insert;

    localparam int HL = 42;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [8*HL-1:0] hdr_template;
    logic [15:0]     payload_len;
    logic [15:0]     pkt_count;

    header_insert_if s_if ();
    header_insert_if m_if ();

    header_insert #(
        .HEADER_LEN (HL),
        .IP_LEN_OFS (16),
        .UDP_LEN_OFS(38)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hdr_template(hdr_template),
        .payload_len (payload_len),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         pkt_no = 0;
    logic [8:0] exp_q[$];
    logic       bp_mode = 1'b0;
    logic       sb_en = 1'b1;
    int         out_cnt = 0;
    int         mark_cnt = -1;
    int         first_hs_cyc = 0;
    int         last_hs_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = 9'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference header byte i for a given template / payload length.
    function automatic logic [7:0] exp_hdr(input int i, input logic [8*HL-1:0] t,
                                           input logic [15:0] pl);
        logic [7:0] b;
        b = t[8*HL-1-8*i -: 8];
`ifdef HEADER_INSERT_LEN_PATCH_EN
        begin
            logic [15:0] ipl;
            logic [15:0] udpl;
            ipl  = pl + 16'd28;
            udpl = pl + 16'd8;
            if (i == 16) b = ipl[15:8];
            if (i == 17) b = ipl[7:0];
            if (i == 38) b = udpl[15:8];
            if (i == 39) b = udpl[7:0];
        end
`else
        if (pl === 16'hxxxx) b = 8'h00;
`endif
        return b;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: always on, or ready one cycle in three.
    initial m_if.tready = 1'b1;
    always @(posedge clk) begin
        #1;
        m_if.tready = bp_mode ? ((cyc % 3) == 0) : 1'b1;
    end

    // Output monitor: sampled mid-cycle, ahead of the edge that transfers.
    always @(negedge clk) begin
        logic [8:0] word;
        logic [8:0] exp;
        word = {m_if.tlast, m_if.tdata};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (sb_en && prev_stall) begin
                check("hold_valid", 32'(m_if.tvalid), 32'd1);
                check("hold_word", 32'(word), 32'(prev_word));
            end
            if (sb_en && m_if.tvalid && !m_if.tready) begin
                check("s_ready_stall", 32'(s_if.tready), 32'd0);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        check("extra_byte", 32'(word), 32'h1ff);
                    end else begin
                        exp = exp_q.pop_front();
                        check("out_byte", 32'(word), 32'(exp));
                    end
                end
                if (out_cnt == mark_cnt) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                out_cnt++;
            end
            prev_stall = sb_en && m_if.tvalid && !m_if.tready;
            prev_word  = word;
        end
    end

    // Queue the expected frame, then offer the payload bytes one by one.
    task automatic send_pkt(input int n, input logic [7:0] base);
        logic [7:0] b;
        logic       hs;
        int         guard;
        for (int i = 0; i < HL; i++) begin
            exp_q.push_back({1'b0, exp_hdr(i, hdr_template, payload_len)});
        end
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, b});
        end
        pkt_no++;
        $display("pkt %0d: %0d payload bytes from 0x%02h, payload_len 0x%04h",
                 pkt_no, n, base, payload_len);
        for (int i = 0; i < n; i++) begin
            s_if.tdata  = base + 8'(i);
            s_if.tlast  = (i == n - 1);
            s_if.tvalid = 1'b1;
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < 1000) begin
                @(negedge clk);
                hs = s_if.tready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!hs) check("s_handshake_timeout", 32'd1, 32'd0);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'd0;
        s_if.tlast  = 1'b0;
        payload_len = 16'd3;
        for (int i = 0; i < HL; i++) hdr_template[8*HL-1-8*i -: 8] = 8'(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_tdata", 32'(m_if.tdata), 32'd0);
        check("rst_tlast", 32'(m_if.tlast), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_s_tready", 32'(s_if.tready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single packet, header byte 0 one cycle after s_tvalid.
        fork
            send_pkt(3, 8'hA1);
            begin
                @(posedge clk);
                #1;
                check("lat_tvalid", 32'(m_if.tvalid), 32'd1);
                check("lat_byte0", 32'(m_if.tdata), 32'd0);
            end
        join
        drain();
        check("pkt_count_single", 32'(pkt_count), 32'd1);

        // Back-to-back 1-byte payloads: 86 bytes in 86 consecutive cycles.
        mark_cnt = out_cnt;
        send_pkt(1, 8'h51);
        send_pkt(1, 8'h61);
        drain();
        check("b2b_span", 32'(last_hs_cyc - first_hs_cyc), 32'd85);
        check("pkt_count_b2b", 32'(pkt_count), 32'd3);

        // Backpressure during header and payload.
        bp_mode = 1'b1;
        send_pkt(4, 8'hC0);
        drain();
        bp_mode = 1'b0;
        check("pkt_count_bp", 32'(pkt_count), 32'd4);

        // Template changed five cycles into the header.
        fork
            send_pkt(2, 8'hD0);
            begin
                guard = 0;
                while (!m_if.tvalid && guard < 100) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                check("tmpl_start_seen", 32'(m_if.tvalid), 32'd1);
                repeat (5) @(posedge clk);
                #1;
                for (int i = 0; i < HL; i++) hdr_template[8*HL-1-8*i -: 8] = 8'hFF - 8'(i);
            end
        join
        drain();
        check("pkt_count_tmpl", 32'(pkt_count), 32'd5);
        for (int i = 0; i < HL; i++) hdr_template[8*HL-1-8*i -: 8] = 8'(i);

        // Length fields (patched only when the feature is compiled in).
        payload_len = 16'h0100;
        send_pkt(2, 8'hE0);
        drain();
        check("pkt_count_len", 32'(pkt_count), 32'd6);

        // Reset while payload is streaming.
        sb_en       = 1'b0;
        mark_cnt    = -1;
        guard       = out_cnt;
        s_if.tdata  = 8'hB0;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        for (int k = 0; k < 200 && out_cnt < guard + HL + 2; k++) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_reached", 32'(out_cnt >= guard + HL + 2), 32'd1);
        rst         = 1'b1;
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rstmid_tdata", 32'(m_if.tdata), 32'd0);
        check("rstmid_tlast", 32'(m_if.tlast), 32'd0);
        check("rstmid_pkt_count", 32'(pkt_count), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        sb_en = 1'b1;
        @(posedge clk);
        #1;
        fork
            send_pkt(2, 8'hF0);
            begin
                @(posedge clk);
                #1;
                check("fresh_tvalid", 32'(m_if.tvalid), 32'd1);
                check("fresh_byte0", 32'(m_if.tdata), 32'(exp_hdr(0, hdr_template, payload_len)));
            end
        join
        drain();
        check("pkt_count_after_rst", 32'(pkt_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/header_insert.md
# header_insert

Transmit-side AXI-Stream header inserter: prepends a HEADER_LEN-byte header (Ethernet/IP/UDP by default) to each outgoing payload packet. It sits between the TX message builder and the MAC byte stream, and is the mirror of the RX header-skip stage. The header bytes come from a template port that is sampled once per packet. The output is a fully registered, backpressure-correct AXIS byte stream with no bubbles between header and payload or between packets.

## Interface
- HEADER_LEN, 42, number of header bytes emitted before each payload; must be >= 2.
- IP_LEN_OFS, 16, byte index of the IPv4 total-length field (MSB first) within the header.
- UDP_LEN_OFS, 38, byte index of the UDP length field (MSB first) within the header.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- hdr_template  in  8*HEADER_LEN  header bytes; byte 0 is bits [8*HEADER_LEN-1 -: 8].
- payload_len  in  16  payload byte count of the packet about to start.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tready  out  1  payload accept.
- s_axis_tlast  in  1  last payload byte.
- m_axis_tdata  out  8  framed byte.
- m_axis_tvalid  out  1  framed valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  last framed byte.
- pkt_count  out  16  count of framed packets completed, wrapping.

## Operation
- **Output register:** a single output register holds m_axis_tdata, m_axis_tvalid and m_axis_tlast.
  - "Load enable" = !m_axis_tvalid || m_axis_tready.
  - While load enable is 0, the register contents are held stable.
  - When load enable is 1 and nothing is loaded, m_axis_tvalid drops to 0.
- **s_axis_tready** = (state == PAYLOAD) && load enable. This is combinational and is never asserted outside PAYLOAD.
- **IDLE:**
  - When s_axis_tvalid is 1 and load enable is 1:
    - latch hdr_template and payload_len into internal registers;
    - load header byte 0;
    - set idx = 1 and go to HEADER.
  - The payload byte is not consumed in this cycle.
- **HEADER:**
  - On each load enable, load latched header byte idx with tlast = 0, then idx++.
  - When byte HEADER_LEN-1 is loaded, go to PAYLOAD.
- **PAYLOAD:**
  - On each s_axis handshake, load s_axis_tdata and s_axis_tlast.
  - If s_axis_tlast is 1: go to IDLE and increment pkt_count.
- **Data source:** the header always comes from the latched template. Changes on hdr_template or payload_len mid-packet have no effect.
- **Payload length:** payload_len is informational unless length patching is compiled in (see Configuration). The frame always ends on the input tlast; a payload_len mismatch is not checked.
- **Counters:** idx is ceil(log2(HEADER_LEN))+1 bits wide. pkt_count wraps 0xFFFF -> 0.

## Timing
- **Reset values:** m_axis_tdata = 0, m_axis_tvalid = 0, m_axis_tlast = 0, pkt_count = 0, state = IDLE, idx = 0.
- **Reset mid-packet:** the partial frame is abandoned and the output returns to the reset values the next cycle. The remaining upstream bytes of that packet are then framed as a new packet; upstream must flush.
- **Latency:** s_axis_tvalid rising in IDLE at cycle N produces header byte 0 on m_axis at cycle N+1.
- **First payload byte:** appears at the earliest at N+1+HEADER_LEN, with tready held at 1.
- **Throughput:** with m_axis_tready held at 1, output is 1 byte/cycle continuously:
  - no gap between the last header byte and payload byte 0;
  - no gap between the tlast byte and header byte 0 of the next packet.
- **Backpressure:** while m_axis_tvalid = 1 and m_axis_tready = 0, m_axis_tdata, m_axis_tvalid, m_axis_tlast and s_axis_tready = 0 are held. No byte is dropped or duplicated.
- **Simultaneous events:** a tlast handshake and the next packet's tvalid in the same cycle are handled in order. The current byte loads, the FSM enters IDLE, and the next header starts on the following load enable.

## Configuration
- Macro: HEADER_INSERT_LEN_PATCH_EN.
- **Defined:** at latch time, the header bytes at IP_LEN_OFS/IP_LEN_OFS+1 are replaced with payload_len+28, and the bytes at UDP_LEN_OFS/UDP_LEN_OFS+1 with payload_len+8.
  - Both values are 16-bit, MSB first, wrapping modulo 2^16.
  - The template's IP checksum is still passed through unchanged.
- **Undefined:** the header is emitted exactly as in the template, payload_len is ignored, and no patch logic is synthesized.

## Test plan
- **Single packet:** HEADER_LEN=42, template byte i = i, 3-byte payload A1 A2 A3 (tlast on A3), tready=1 -> 45 bytes 00..29 A1 A2 A3; tlast only on A3; pkt_count=1; header byte 0 one cycle after s_tvalid.
- **Back-to-back:** two 1-byte payloads presented continuously -> 86 output bytes in 86 consecutive cycles with no tvalid gap; pkt_count=2.
- **Backpressure:** m_tready toggling with a 1-of-3 pattern during header and payload -> output stream identical to the no-backpressure case; tdata stable whenever tvalid=1 and tready=0.
- **Template change:** hdr_template changed at cycle 5 of the header -> all 42 bytes come from the template value sampled at cycle N.
- **Length patch:** with HEADER_INSERT_LEN_PATCH_EN defined, payload_len=0x0100 -> bytes 16,17 = 01,1C and bytes 38,39 = 01,08. Without the macro, template bytes are unchanged.
- **Reset mid-packet:** rst asserted during payload byte 2 -> next cycle m_tvalid=0, pkt_count=0; the next s_tvalid starts a fresh header at byte 0.
